// File: rtl/cnt_updown.sv
// Parametrised synchronous up/down counter with enable, prescaler, clear, load and terminal-count pulse.
// Define CNT_SAT_EN for saturating mode (hold at the bounds); default build wraps.
module cnt_updown #(
  parameter int WIDTH    = 4,
  parameter int MAX      = 2**WIDTH-1,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc
);

  localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    pre;
  logic [PW-1:0]    pre_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic             tc_nxt;
  logic             step;
  logic             at_bound;

  assign step     = en && (pre == PRE_LAST);
  // The bound that matters depends on the direction sampled on this step edge.
  assign at_bound = up ? (out == MAX_V) : (out == '0);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    out_nxt = out;
    pre_nxt = pre;
    tc_nxt  = 1'b0;
    if (clr) begin
      out_nxt = '0;
      pre_nxt = '0;
    end else if (load) begin
      out_nxt = (load_val > MAX_V) ? MAX_V : load_val;
      pre_nxt = '0;
    end else if (step) begin
      pre_nxt = '0;
      tc_nxt  = at_bound;
`ifdef CNT_SAT_EN
      if (!at_bound) out_nxt = up ? out + 1'b1 : out - 1'b1;
`else
      if (at_bound) out_nxt = up ? '0 : MAX_V;
      else          out_nxt = up ? out + 1'b1 : out - 1'b1;
`endif
    end else if (en) begin
      pre_nxt = pre + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (!rstb) begin
      out <= '0;
      pre <= '0;
      tc  <= 1'b0;
    end else begin
      out <= out_nxt;
      pre <= pre_nxt;
      tc  <= tc_nxt;
    end
  end

endmodule
